anillo_barrido_teclado: RTL and testbench
=========================================

Name: anillo_barrido_teclado

Overview:
Parametrised ring-counter keypad scanner. It drives one active row line at a time, rotating at a programmable tick rate. It samples the column lines on each tick. On a detected key, it freezes the ring, debounces the column pattern and emits a one-cycle key event with an encoded {row, column} code. It then waits for release and resumes scanning. It sits between the keypad pins and the key-decoding logic.

Parameters:
N_FILAS, 4, number of row lines driven by the ring; legal range ≥2.
N_COLS, 4, number of column inputs; legal range ≥2.
TICK_DIV, 1000, clk cycles per scan tick; legal range ≥1.
DEB_TICKS, 4, consecutive stable ticks required to accept a press and to accept a release; legal range ≥1.
ACT_LOW, 0, pin polarity for both fila and col: 0 = active-high, 1 = active-low.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high. One clock; all state is updated on the rising edge of clk.
en  in  1  scan enable; gates tick generation.
col  in  N_COLS  raw column pins, asynchronous to clk.
fila  out  N_FILAS  row drive, one-hot (or one-cold when ACT_LOW=1).
key_valid  out  1  one-cycle pulse when a key is accepted.
key_code  out  RW+CW  {row_idx, col_idx}, where RW = max(1, clog2 N_FILAS) and CW = max(1, clog2 N_COLS).
busy  out  1  high whenever the FSM is not in SCAN.

Behaviour:
- Reset (rst dominates en and every other input):
  - fila = bit0 active, i.e. 0001, or 1110 when ACT_LOW=1.
  - row_idx = 0.
  - key_valid = 0, key_code = 0, busy = 0.
  - State = SCAN; tick counter = 0; debounce and release counters = 0.
  - Both synchroniser stages are loaded with the inactive column level.
- Column input path:
  - col passes through a 2-flop synchroniser (2-cycle latency).
  - The synchronised value is normalised to active-high internally (XOR with ACT_LOW) to give col_s.
- Tick generation:
  - The counter runs 0..TICK_DIV-1 while en=1 and holds its value while en=0.
  - tick = 1 for one cycle when the counter is at TICK_DIV-1 and en=1; the counter then wraps to 0.
  - With TICK_DIV=1, tick = en.
- SCAN state:
  - On a tick with col_s == 0: rotate the ring left. The MSB wraps to bit0, and row_idx increments modulo N_FILAS.
  - On a tick with col_s != 0: snapshot col_s, set the debounce counter to 1, go to DEBOUNCE. fila is frozen from this point.
- DEBOUNCE state (acts only on ticks):
  - col_s == snapshot: increment the debounce counter.
  - Debounce counter reaches DEB_TICKS: go to PRESSED.
  - col_s != snapshot: go to SCAN with no rotation on that tick; the same row is re-evaluated on the next tick.
  - With DEB_TICKS=1, go to PRESSED on the entry tick's successor check; there is no extra tick.
- PRESSED state (exactly one clk cycle, independent of en):
  - key_valid = 1.
  - key_code = {row_idx, index of the lowest set bit of the snapshot}; the lowest column wins when several columns are set.
  - Next state is RELEASE unconditionally.
- RELEASE state:
  - On each tick with col_s == 0, increment the release counter.
  - Any tick with col_s != 0 clears the release counter.
  - Release counter reaches DEB_TICKS: go to SCAN. The ring stays on the same row; rotation resumes on the next tick.
- Output and timing rules:
  - key_code holds its value until the next PRESSED.
  - key_valid is 0 in every state other than PRESSED.
  - busy = (state != SCAN), registered, so it changes on the same edge as the state.
  - fila is registered; polarity is applied at the output.
  - en=0 freezes every tick-driven transition; a PRESSED pulse already in progress still completes.
  - rst asserted in any state returns all outputs to their reset values on the next edge and cancels any pending key_valid.

Test Plan:
1. Free-running scan (TICK_DIV=4, ACT_LOW=0, col=0, en=1, after rst) -> fila sequence 0001, 0010, 0100, 1000, 0001 with a step every 4 clk; busy=0; key_valid never asserts.
2. Enable pause (drop en for 10 cycles while fila=0100) -> fila holds 0100; after en returns, the next step comes exactly (TICK_DIV minus elapsed count) cycles later.
3. Valid press (keypad model, key at row 2/col 1, DEB_TICKS=4) -> fila freezes at 0100 and busy=1. One key_valid pulse follows DEB_TICKS ticks later, with key_code=4'b1001. On release, after 4 zero ticks busy=0, then fila goes to 1000 on the following tick.
4. Bounce (key asserted for 2 ticks then released, DEB_TICKS=4) -> no key_valid; state returns to SCAN; rotation resumes from the frozen row.
5. Multi-column press (cols 1 and 3 on row 0) -> a single key_valid with key_code=4'b0001.
6. Active-low plus reset mid-operation (ACT_LOW=1, assert rst during DEBOUNCE) -> on the next edge fila=1110, busy=0, key_valid=0, key_code=0; after release of rst, scanning restarts from row 0.

Source files
------------

// File: rtl/anillo_barrido_teclado.sv
// Ring-counter keypad scanner: one active row per tick, freezes on a hit, debounces press and release.
// Columns go through a 2-flop synchroniser; no backpressure, key_valid is a single-cycle pulse.
module anillo_barrido_teclado #(
   parameter int N_FILAS   = 4,
   parameter int N_COLS    = 4,
   parameter int TICK_DIV  = 1000,
   parameter int DEB_TICKS = 4,
   parameter int ACT_LOW   = 0,
   localparam int RW = (N_FILAS > 1) ? $clog2(N_FILAS) : 1,
   localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [N_COLS-1:0]  col,
   output logic [N_FILAS-1:0] fila,
   output logic               key_valid,
   output logic [RW+CW-1:0]   key_code,
   output logic               busy
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = $clog2(DEB_TICKS + 2);
   localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0]      DEB_LAST  = DW'(DEB_TICKS - 1);
   localparam logic               ACT_LVL   = (ACT_LOW != 0);
   localparam logic [N_COLS-1:0]  COL_IDLE  = {N_COLS{ACT_LVL}};
   localparam logic [N_FILAS-1:0] RING_RST  = N_FILAS'(1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} estado_t;

   estado_t             state_q, state_d;
   logic [N_COLS-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
   logic [N_COLS-1:0]   snap_q, snap_d;
   logic [N_COLS-1:0]   col_s;
   logic [TW-1:0]       cnt_q, cnt_d;
   logic                tick;
   logic [N_FILAS-1:0]  ring_q, ring_d;
   logic [RW-1:0]       row_q, row_d;
   logic [DW-1:0]       deb_q, deb_d, rel_q, rel_d;
   logic                key_valid_q, key_valid_d;
   logic                busy_q, busy_d;
   logic [RW+CW-1:0]    key_code_q, key_code_d;
   logic [CW-1:0]       low_idx;

   assign col_s = sync2_q ^ COL_IDLE;

   // Descending sweep so the lowest set column is the last one written.
   always_comb begin
      low_idx = '0;
      for (int i = N_COLS - 1; i >= 0; i--) begin
         if (snap_q[i]) low_idx = CW'(i);
      end
   end

   always_comb begin
      sync1_d    = col;
      sync2_d    = sync1_q;
      state_d    = state_q;
      ring_d     = ring_q;
      row_d      = row_q;
      snap_d     = snap_q;
      deb_d      = deb_q;
      rel_d      = rel_q;
      key_code_d = key_code_q;

      tick  = en && (cnt_q == TICK_LAST);
      cnt_d = cnt_q;
      if (en) cnt_d = tick ? '0 : cnt_q + TW'(1);

      case (state_q)
         SCAN: begin
            if (tick) begin
               if (col_s == '0) begin
                  ring_d = {ring_q[N_FILAS-2:0], ring_q[N_FILAS-1]};
                  row_d  = (row_q == RW'(N_FILAS - 1)) ? '0 : row_q + RW'(1);
               end else begin
                  snap_d  = col_s;
                  deb_d   = DW'(1);
                  state_d = DEBOUNCE;
               end
            end
         end
         DEBOUNCE: begin
            // A changed pattern drops back to SCAN without rotating, so the row is re-sampled.
            if (tick) begin
               if (col_s == snap_q) begin
                  if (deb_q >= DEB_LAST) begin
                     state_d    = PRESSED;
                     key_code_d = {row_q, low_idx};
                  end else begin
                     deb_d = deb_q + DW'(1);
                  end
               end else begin
                  state_d = SCAN;
               end
            end
         end
         PRESSED: begin
            state_d = RELEASE;
            rel_d   = '0;
         end
         default: begin
            if (tick) begin
               if (col_s == '0) begin
                  if (rel_q >= DEB_LAST) begin
                     state_d = SCAN;
                     rel_d   = '0;
                  end else begin
                     rel_d = rel_q + DW'(1);
                  end
               end else begin
                  rel_d = '0;
               end
            end
         end
      endcase

      key_valid_d = (state_d == PRESSED);
      busy_d      = (state_d != SCAN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= COL_IDLE;
         sync2_q     <= COL_IDLE;
         cnt_q       <= '0;
         state_q     <= SCAN;
         ring_q      <= RING_RST;
         row_q       <= '0;
         snap_q      <= '0;
         deb_q       <= '0;
         rel_q       <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         ring_q      <= ring_d;
         row_q       <= row_d;
         snap_q      <= snap_d;
         deb_q       <= deb_d;
         rel_q       <= rel_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         busy_q      <= busy_d;
      end
   end

   assign fila      = ring_q ^ {N_FILAS{ACT_LVL}};
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_anillo_barrido_teclado.sv
// Bench for the keypad scanner: active-high and active-low instances share one keypad and one reference model.
module tb_anillo_barrido_teclado;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int TICK = 4;
   localparam int DEB  = 4;
   localparam int WAIT_KEY  = 0;
   localparam int CONFIRM   = 1;
   localparam int REPORT    = 2;
   localparam int WAIT_LIFT = 3;

   logic       clk = 1'b0;
   logic       rst, en;
   logic [3:0] col0, col1, fila0, fila1, kc0, kc1;
   logic       kv0, kv1, busy0, busy1;
   logic [3:0] keys [4];

   int total = 0;
   int bad = 0;
   int kv_count = 0;

   // reference model state
   int         m_row, m_mode, m_timer, m_stable, m_zeros, m_kc;
   bit         m_kv;
   logic [3:0] m_snap;
   logic [3:0] m_pipe [2];

   always #5 clk = ~clk;

   anillo_barrido_teclado #(.N_FILAS(ROWS), .N_COLS(COLS), .TICK_DIV(TICK), .DEB_TICKS(DEB), .ACT_LOW(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .col(col0), .fila(fila0),
      .key_valid(kv0), .key_code(kc0), .busy(busy0));

   anillo_barrido_teclado #(.N_FILAS(ROWS), .N_COLS(COLS), .TICK_DIV(TICK), .DEB_TICKS(DEB), .ACT_LOW(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .col(col1), .fila(fila1),
      .key_valid(kv1), .key_code(kc1), .busy(busy1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expire(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   function automatic int lowest(input logic [3:0] m);
      for (int i = 0; i < COLS; i++) if (m[i]) return i;
      return 0;
   endfunction

   function automatic logic [3:0] keypad(input logic [3:0] f);
      int hits = 0;
      int r = 0;
      for (int i = 0; i < ROWS; i++) begin
         if (f[i] === 1'b1) begin
            hits++;
            r = i;
         end
      end
      return (hits == 1) ? keys[r] : 4'b0000;
   endfunction

   task automatic model_step(input logic r, input logic e, input logic [3:0] c);
      logic [3:0] cs;
      bit tk;
      if (r) begin
         m_row = 0; m_mode = WAIT_KEY; m_timer = 0; m_stable = 0; m_zeros = 0;
         m_kv = 1'b0; m_kc = 0; m_snap = 4'b0; m_pipe[0] = 4'b0; m_pipe[1] = 4'b0;
      end else begin
         cs = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = c;
         tk = e && (m_timer == TICK - 1);
         if (e) m_timer = (m_timer + 1) % TICK;
         m_kv = 1'b0;
         case (m_mode)
            WAIT_KEY: if (tk) begin
               if (cs == 4'b0) m_row = (m_row + 1) % ROWS;
               else begin
                  m_snap = cs; m_stable = 1; m_mode = CONFIRM;
               end
            end
            CONFIRM: if (tk) begin
               if (cs == m_snap) begin
                  m_stable++;
                  if (m_stable >= DEB) begin
                     m_mode = REPORT;
                     m_kv = 1'b1;
                     m_kc = m_row * COLS + lowest(m_snap);
                  end
               end else m_mode = WAIT_KEY;
            end
            REPORT: begin
               m_mode = WAIT_LIFT;
               m_zeros = 0;
            end
            default: if (tk) begin
               if (cs == 4'b0) begin
                  m_zeros++;
                  if (m_zeros >= DEB) m_mode = WAIT_KEY;
               end else m_zeros = 0;
            end
         endcase
      end
   endtask

   // keypad: the pressed keys of the currently driven row appear on the columns
   initial begin
      col0 = 4'b0000;
      col1 = 4'b1111;
      forever begin
         @(negedge clk);
         col0 = keypad(fila0);
         col1 = ~col0;
      end
   end

   // compare process: advance the model on each rising edge, check both DUTs on the falling edge
   initial begin
      logic r_s, e_s;
      logic [3:0] c_s, ef, ef_n;
      bit live;
      live = 1'b0;
      forever begin
         @(posedge clk);
         r_s = rst; e_s = en; c_s = col0;
         model_step(r_s, e_s, c_s);
         if (r_s === 1'b1) live = 1'b1;
         @(negedge clk);
         if (live) begin
            ef = 4'(1 << m_row);
            ef_n = ~ef;
            chk("fila0", 32'(fila0), 32'(ef));
            chk("fila1", 32'(fila1), 32'(ef_n));
            chk("kv0", 32'(kv0), 32'(m_kv));
            chk("kv1", 32'(kv1), 32'(m_kv));
            chk("kc0", 32'(kc0), m_kc);
            chk("kc1", 32'(kc1), m_kc);
            chk("busy0", 32'(busy0), 32'(m_mode != WAIT_KEY));
            chk("busy1", 32'(busy1), 32'(m_mode != WAIT_KEY));
            if (kv0 === 1'b1) kv_count++;
         end
      end
   end

   task automatic clear_keys();
      for (int i = 0; i < ROWS; i++) keys[i] = 4'b0000;
   endtask

   task automatic wait_change(input string name, input int budget, output int n);
      logic [3:0] f0;
      f0 = fila0;
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (fila0 !== f0) begin
            n = i;
            break;
         end
      end
      if (n < 0) expire(name);
   endtask

   // sel 0 watches busy0, sel 1 watches key_valid0
   task automatic wait_sig(input string name, input int sel, input logic lvl, input int budget);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (((sel == 0) ? busy0 : kv0) === lvl) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) expire(name);
   endtask

   initial begin
      int n, kvb;
      logic [3:0] scan_exp [4];
      scan_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      clear_keys();
      rst = 1'b1;
      en  = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_fila0", 32'(fila0), 32'b0001);
      chk("rst_fila1", 32'(fila1), 32'b1110);
      chk("rst_busy", 32'(busy0), 32'b0);
      chk("rst_kv", 32'(kv0), 32'b0);
      chk("rst_kc", 32'(kc0), 32'b0);
      rst = 1'b0;

      // free-running scan
      for (int s = 0; s < 4; s++) begin
         wait_change("scan_step", 10, n);
         chk("scan_step_cycles", n, 4);
         chk("scan_fila", 32'(fila0), 32'(scan_exp[s]));
      end

      // enable pause one cycle into the 0100 period
      wait_change("to_0010", 10, n);
      wait_change("to_0100", 10, n);
      chk("pause_start_fila", 32'(fila0), 32'b0100);
      @(negedge clk);
      en = 1'b0;
      repeat (10) @(negedge clk);
      chk("pause_hold_fila", 32'(fila0), 32'b0100);
      en = 1'b1;
      wait_change("resume", 10, n);
      chk("resume_cycles", n, 3);
      chk("resume_fila", 32'(fila0), 32'b1000);

      // valid press at row 2, column 1
      kvb = kv_count;
      keys[2] = 4'b0010;
      wait_sig("press_busy", 0, 1'b1, 100);
      chk("press_frozen_fila", 32'(fila0), 32'b0100);
      wait_sig("press_kv", 1, 1'b1, 100);
      chk("press_code", 32'(kc0), 32'b1001);
      chk("model_code", m_kc, 9);
      clear_keys();
      wait_sig("release_busy", 0, 1'b0, 100);
      chk("release_same_row", 32'(fila0), 32'b0100);
      wait_change("release_rotate", 10, n);
      chk("release_next_fila", 32'(fila0), 32'b1000);
      chk("release_next_cycles", n, 4);
      chk("press_one_pulse", kv_count - kvb, 1);

      // bounce on row 1: held for about two ticks only
      kvb = kv_count;
      keys[1] = 4'b0100;
      wait_sig("bounce_busy", 0, 1'b1, 100);
      chk("bounce_fila", 32'(fila0), 32'b0010);
      repeat (4) @(negedge clk);
      clear_keys();
      wait_sig("bounce_back", 0, 1'b0, 100);
      chk("bounce_no_kv", kv_count - kvb, 0);
      wait_change("bounce_resume", 10, n);
      chk("bounce_resume_fila", 32'(fila0), 32'b0100);

      // two columns on row 0: lowest column wins
      keys[0] = 4'b1010;
      wait_sig("multi_busy", 0, 1'b1, 100);
      wait_sig("multi_kv", 1, 1'b1, 100);
      chk("multi_code", 32'(kc0), 32'b0001);
      chk("model_multi_code", m_kc, 1);
      clear_keys();
      wait_sig("multi_release", 0, 1'b0, 100);

      // randomized presses, gaps, enable gaps and occasional reset
      for (int ep = 0; ep < 60; ep++) begin
         int hold, gap;
         keys[$urandom_range(0, 3)] = 4'($urandom_range(1, 15));
         hold = $urandom_range(0, 60);
         for (int k = 0; k < hold; k++) begin
            en = ($urandom_range(0, 7) != 0);
            @(negedge clk);
         end
         clear_keys();
         gap = $urandom_range(0, 40);
         for (int k = 0; k < gap; k++) begin
            en = ($urandom_range(0, 7) != 0);
            @(negedge clk);
         end
         if ($urandom_range(0, 14) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end
      en = 1'b1;
      wait_sig("random_settle", 0, 1'b0, 300);

      // reset during debounce, active-low instance
      keys[3] = 4'b0100;
      wait_sig("al_busy", 0, 1'b1, 100);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("al_rst_fila1", 32'(fila1), 32'b1110);
      chk("al_rst_fila0", 32'(fila0), 32'b0001);
      chk("al_rst_busy", 32'(busy1), 32'b0);
      chk("al_rst_kv", 32'(kv1), 32'b0);
      chk("al_rst_kc", 32'(kc1), 32'b0);
      clear_keys();
      rst = 1'b0;
      wait_change("al_restart", 10, n);
      chk("al_restart_fila1", 32'(fila1), 32'b1101);
      chk("al_restart_cycles", n, 4);

      repeat (10) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      total++;
      bad++;
      $display("FAIL watchdog: run exceeded time limit");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
